// File: rtl/aes_pipe_scheduler_if.sv
// Handshake and data bundle between the AES scheduler and its environment
// (two requesters, the pipelined AES core and the result consumer).
interface aes_pipe_scheduler_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic [127:0] core_din;
  logic [127:0] core_key;
  logic [127:0] core_dout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_id;
  logic         busy;
  logic [31:0]  blocks_done;

  // Environment side: requesters, AES core output and result consumer
  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output core_dout, out_ready,
    input  req0_ready, req1_ready, core_din, core_key,
    input  out_valid, out_data, out_id, busy, blocks_done
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  core_dout, out_ready,
    output req0_ready, req1_ready, core_din, core_key,
    output out_valid, out_data, out_id, busy, blocks_done
  );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Front-end scheduler for a LATENCY-deep pipelined AES-128 core: round-robin
// arbitration of two requesters, credit-limited issue, a tag pipeline that
// tracks each block through the core, and an output FIFO with backpressure.
module aes_pipe_scheduler #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  aes_pipe_scheduler_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  logic               r_last_grant;
  logic [127:0]       r_core_din;
  logic [127:0]       r_core_key;
  logic [LATENCY:0]   r_tag_valid;
  logic [LATENCY:0]   r_tag_id;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   r_fifo_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [31:0]        r_blocks_done;
  logic [127:0]       r_fifo_data [FIFO_DEPTH];
  logic               r_fifo_id   [FIFO_DEPTH];

  logic w_credit_ok;
  logic w_grant0;
  logic w_grant1;
  logic w_accept0;
  logic w_accept1;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_out_valid;

  // Credit counts every block already committed to the FIFO (in the core or
  // buffered); a pop in this cycle only frees credit once the counts update.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_fifo_count}) < CREDIT_LIMIT;

  // req0 wins unless req1 also asks and req0 was the last one served
  assign w_grant0  = bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1  = bus.req1_valid & ~w_grant0;
  assign w_accept0 = bus.req0_valid & w_credit_ok & w_grant0;
  assign w_accept1 = bus.req1_valid & w_credit_ok & w_grant1;
  assign w_accept  = w_accept0 | w_accept1;

  // A block leaves the core when its tag reaches the last stage
  assign w_push      = r_tag_valid[LATENCY];
  assign w_out_valid = (r_fifo_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;

  assign bus.req0_ready  = w_credit_ok & w_grant0;
  assign bus.req1_ready  = w_credit_ok & w_grant1;
  assign bus.core_din    = r_core_din;
  assign bus.core_key    = r_core_key;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.out_id      = w_out_valid ? r_fifo_id[r_rd_ptr] : 1'b0;
  assign bus.busy        = (r_inflight != '0) | (r_fifo_count != '0);
  assign bus.blocks_done = r_blocks_done;

  // Issue: latch the granted plaintext/key into the core and remember the winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_core_din   <= '0;
      r_core_key   <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_accept1;
      r_core_din   <= w_accept1 ? bus.req1_data : bus.req0_data;
      r_core_key   <= w_accept1 ? bus.req1_key  : bus.req0_key;
    end
  end

  // Tag pipeline: shifts every cycle so a tag lines up with its core_dout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_valid <= '0;
      r_tag_id    <= '0;
    end else begin
      r_tag_valid <= {r_tag_valid[LATENCY-1:0], w_accept};
      r_tag_id    <= {r_tag_id[LATENCY-1:0], w_accept1};
    end
  end

  // Occupancy counters, FIFO pointers and the popped-block counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight    <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_blocks_done <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + PTR_W'(1);
        r_blocks_done <= r_blocks_done + 32'd1;
      end
    end
  end

  // FIFO storage; stale contents are harmless because the pointers/count reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.core_dout;
      r_fifo_id[r_wr_ptr]   <= r_tag_id[LATENCY];
    end
  end

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Self-checking bench for aes_pipe_scheduler: behavioural AES core model,
// known-answer vector table, and a queue-based scoreboard that predicts
// readiness, result order, exact latency, busy and blocks_done.
module tb_aes_pipe_scheduler;
  localparam int LATENCY    = 10;
  localparam int FIFO_DEPTH = 16;

  logic clock;
  logic reset_n;
  aes_pipe_scheduler_if bus ();

  aes_pipe_scheduler #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0]  inv;
    logic [15:0] dd;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    dd = {inv, inv};
    return inv ^ dd[14:7] ^ dd[13:6] ^ dd[12:5] ^ dd[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] rk, st;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp, w0, w1, w2, w3;
    logic [7:0]   rcon, a0, a1, a2, a3;
    rk = key; st = pt ^ key; rcon = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = {rk[23:0], rk[31:24]};
      tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rcon, 24'h0};
      w0 = rk[127:96] ^ tmp; w1 = rk[95:64] ^ w0; w2 = rk[63:32] ^ w1; w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rcon = xt(rcon);
      for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = s[q + 4*((c+q)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
      st = st ^ rk;
    end
    return st;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
  end

  // Pipelined core model: no reset, result appears LATENCY edges after input change
  logic [127:0] core_pipe [LATENCY];
  always @(posedge clock) begin
    core_pipe[0] <= aes_enc(bus.core_din, bus.core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign bus.core_dout = core_pipe[LATENCY-1];

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct { logic [127:0] ct; logic id; int avail; } exp_t;
  typedef struct { logic [127:0] d; logic [127:0] k; } blk_t;
  typedef struct { logic id; logic [127:0] key; logic [127:0] pt; logic [127:0] ct; } vec_t;

  exp_t        m_q[$];
  int          m_out;
  logic [31:0] m_done;
  logic        m_last;
  bit          mon_en = 0;
  int          cyc = 0;
  int          acc_ids[$];
  int          acc_cycs[$];
  int          pop_cycs[$];
  logic [127:0] last_pop_data;
  logic         last_pop_id;
  int           last_pop_cyc, last_acc_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: predicts the observable behaviour each cycle from the queue of accepted blocks
  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      int winner;
      bit a0, a1, expv;
      winner = -1;
      if (bus.req0_valid && bus.req1_valid) winner = m_last ? 0 : 1;
      else if (bus.req0_valid) winner = 0;
      else if (bus.req1_valid) winner = 1;
      if (m_out >= FIFO_DEPTH) winner = -1;
      chk("req0_ready", bus.req0_ready, winner == 0);
      chk("req1_ready", bus.req1_ready, winner == 1);
      expv = (m_q.size() > 0) && (m_q[0].avail <= cyc);
      chk("out_valid", bus.out_valid, expv);
      if (bus.out_valid && expv) begin
        chk("out_data", bus.out_data, m_q[0].ct);
        chk("out_id", bus.out_id, m_q[0].id);
      end else if (!bus.out_valid) begin
        chk("idle_out_data", bus.out_data, 0);
        chk("idle_out_id", bus.out_id, 0);
      end
      chk("busy", bus.busy, m_out != 0);
      chk("blocks_done", bus.blocks_done, m_done);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (bus.out_valid && bus.out_ready && expv) begin
        $display("[%0d] pop    id=%0d data=%h", cyc, bus.out_id, bus.out_data);
        last_pop_data = bus.out_data;
        last_pop_id   = bus.out_id;
        last_pop_cyc  = cyc;
        pop_cycs.push_back(cyc);
        void'(m_q.pop_front());
        m_out--;
        m_done++;
      end
      if (a0 || a1) begin
        exp_t e;
        e.id    = a0 ? 1'b0 : 1'b1;
        e.ct    = a0 ? aes_enc(bus.req0_data, bus.req0_key) : aes_enc(bus.req1_data, bus.req1_key);
        e.avail = cyc + LATENCY + 2;
        m_q.push_back(e);
        $display("[%0d] accept id=%0d expect=%h", cyc, e.id, e.ct);
        acc_ids.push_back(int'(e.id));
        acc_cycs.push_back(cyc);
        last_acc_cyc = cyc;
        m_last = e.id;
        m_out++;
      end
    end
  end

  // ---------------- stimulus ----------------
  blk_t pend0[$];
  blk_t pend1[$];
  int   or_mode;
  bit   gate_rand;

  function automatic blk_t rnd_blk();
    blk_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom};
    b.k = {$urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  // stop_mode 0: until everything drained; 1: fixed cycle count; 2: until 3 results sit in the FIFO
  task automatic drive(input int stop_mode, input int budget);
    int n;
    bit a0, a1;
    int avail_cnt;
    n = 0;
    forever begin
      if (!bus.req0_valid && pend0.size() > 0 && (!gate_rand || $urandom_range(0, 1) == 1)) begin
        bus.req0_valid = 1'b1; bus.req0_data = pend0[0].d; bus.req0_key = pend0[0].k;
      end
      if (!bus.req1_valid && pend1.size() > 0 && (!gate_rand || $urandom_range(0, 1) == 1)) begin
        bus.req1_valid = 1'b1; bus.req1_data = pend1[0].d; bus.req1_key = pend1[0].k;
      end
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clock);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clock);
      #1;
      if (a0) begin void'(pend0.pop_front()); bus.req0_valid = 1'b0; end
      if (a1) begin void'(pend1.pop_front()); bus.req1_valid = 1'b0; end
      n++;
      avail_cnt = 0;
      foreach (m_q[i]) if (m_q[i].avail <= cyc) avail_cnt++;
      if (stop_mode == 0 && pend0.size() == 0 && pend1.size() == 0 && !bus.req0_valid
          && !bus.req1_valid && m_q.size() == 0) break;
      if (stop_mode == 1 && n >= budget) break;
      if (stop_mode == 2 && avail_cnt >= 3) break;
      if (stop_mode != 1 && n >= budget) begin
        n_checks++;
        $display("FAIL drive_timeout: ran %0d cycles, limit %0d", n, budget);
        break;
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    pend0.delete();
    pend1.delete();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_blocks_done", bus.blocks_done, 0);
    chk("rst_core_din", bus.core_din, 0);
    chk("rst_core_key", bus.core_key, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    m_q.delete();
    m_out = 0;
    m_done = '0;
    m_last = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    mon_en = 1;
  endtask

  vec_t vecs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    bus.out_ready = 1'b1;
    or_mode = 0;
    gate_rand = 0;
    vecs[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{1'b0, 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    #2;
    do_reset();

    // Known-answer single blocks: data, id, exact latency, idle afterwards
    for (int i = 0; i < 3; i++) begin
      blk_t b;
      b.d = vecs[i].pt; b.k = vecs[i].key;
      if (vecs[i].id) pend1.push_back(b); else pend0.push_back(b);
      drive(0, 100);
      chk("vec_data", last_pop_data, vecs[i].ct);
      chk("vec_id", last_pop_id, vecs[i].id);
      chk("vec_latency", last_pop_cyc - last_acc_cyc, LATENCY + 2);
      chk("vec_busy_after", bus.busy, 0);
      chk("vec_blocks_done", bus.blocks_done, i + 1);
    end

    // Contention: both requesters stream, grants alternate starting with req0
    do_reset();
    acc_ids.delete();
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(rnd_blk());
      if (i == 0) pend1.push_back('{vecs[1].pt, vecs[1].key});
      else pend1.push_back(rnd_blk());
    end
    drive(0, 200);
    for (int i = 0; i < 8; i++) chk("contention_grant", acc_ids[i], i % 2);

    // Backpressure: credit caps acceptances at FIFO_DEPTH, issue resumes one cycle after first pop
    acc_ids.delete(); acc_cycs.delete(); pop_cycs.delete();
    or_mode = 1;
    for (int i = 0; i < 20; i++) pend0.push_back(rnd_blk());
    drive(1, 40);
    chk("bp_accepts", acc_ids.size(), FIFO_DEPTH);
    chk("bp_ready_low", bus.req0_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    or_mode = 0;
    drive(0, 200);
    chk("bp_total", acc_ids.size(), 20);
    chk("bp_pops", pop_cycs.size(), 20);
    chk("bp_resume", acc_cycs[FIFO_DEPTH] - pop_cycs[0], 1);

    // Throughput: 100 back-to-back blocks, one per cycle in and out
    acc_cycs.delete(); pop_cycs.delete();
    for (int i = 0; i < 100; i++) pend0.push_back(rnd_blk());
    drive(0, 400);
    chk("tp_accept_span", acc_cycs[99] - acc_cycs[0], 99);
    chk("tp_pop_span", pop_cycs[99] - pop_cycs[0], 99);
    chk("tp_first_latency", pop_cycs[0] - acc_cycs[0], LATENCY + 2);

    // Randomized traffic from both requesters with random backpressure
    gate_rand = 1; or_mode = 2;
    for (int i = 0; i < 30; i++) begin
      pend0.push_back(rnd_blk());
      pend1.push_back(rnd_blk());
    end
    drive(0, 3000);
    gate_rand = 0; or_mode = 0;

    // Reset with 5 blocks in the core and 3 in the FIFO
    or_mode = 1;
    for (int i = 0; i < 8; i++) pend0.push_back(rnd_blk());
    drive(2, 100);
    chk("mid_pre_out_valid", bus.out_valid, 1);
    chk("mid_pre_busy", bus.busy, 1);
    do_reset();
    or_mode = 0;
    drive(1, 20);
    pend0.push_back('{vecs[0].pt, vecs[0].key});
    drive(0, 100);
    chk("mid_post_data", last_pop_data, vecs[0].ct);
    chk("mid_post_blocks_done", bus.blocks_done, 1);

    // blocks_done wrap: preset to all ones, pop one block
    dut.r_blocks_done = 32'hFFFF_FFFF;
    m_done = 32'hFFFF_FFFF;
    pend1.push_back('{vecs[1].pt, vecs[1].key});
    drive(0, 100);
    chk("wrap_blocks_done", bus.blocks_done, 0);
    chk("wrap_data", last_pop_data, vecs[1].ct);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_pipe_scheduler.md
Name: aes_pipe_scheduler

Overview:
Front-end controller for the 10-round pipelined AES-128 encryption core. It arbitrates two block requesters round-robin, issues at most one plaintext/key pair per cycle into the core, and tracks each block's validity and requester ID through a tag shift register matched to the core latency. Results are captured into an output FIFO with valid/ready backpressure. Credit-based issue guarantees the FIFO never overflows.

Parameters:
LATENCY, 10, clock edges from a core_din/core_key change to the matching core_dout being valid
FIFO_DEPTH, 16, output FIFO entries (power of two, >= 2); also the issue credit limit

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a block
req0_ready  out  1  requester 0 block accepted this cycle
req0_data  in  128  requester 0 plaintext
req0_key  in  128  requester 0 cipher key
req1_valid  in  1  requester 1 has a block
req1_ready  out  1  requester 1 block accepted this cycle
req1_data  in  128  requester 1 plaintext
req1_key  in  128  requester 1 cipher key
core_din  out  128  plaintext to the core
core_key  out  128  key to the core
core_dout  in  128  ciphertext from the core
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  128  ciphertext at FIFO head
out_id  out  1  requester ID of the head block
busy  out  1  any block in flight or buffered
blocks_done  out  32  count of blocks popped from the output

Behaviour:
- Reset (async, reset_n=0): core_din=0, core_key=0, tag pipeline cleared, inflight=0, FIFO empty, out_valid=0, busy=0, blocks_done=0, last_grant=1 (req0 wins first tie).
- Credit: credit_ok = (inflight + fifo_count) < FIFO_DEPTH, computed from registered counts only. A pop in the same cycle does not free credit until the next cycle.
- Arbitration: grant0 = req0_valid & (!req1_valid | last_grant==1); grant1 = req1_valid & !grant0. reqN_ready = credit_ok & grantN (combinational). Acceptance means reqN_valid & reqN_ready. At most one acceptance per cycle. last_grant updates only on acceptance.
- Requesters hold data/key stable while valid & !ready. The scheduler does not drop or reorder accepted blocks.
- Issue: on an acceptance edge, core_din/core_key register the granted data/key. On non-accept cycles they hold their previous value.
- Tag pipeline: LATENCY+1 stages of {valid, id}. Stage 0 is loaded on the acceptance edge; entries shift every cycle. When the last stage is valid, core_dout and its id are written into the FIFO on that edge.
- Latency: a block accepted in cycle T is first on out_valid in cycle T+LATENCY+2 if the FIFO was empty. Back-to-back acceptances give one result per cycle.
- inflight: +1 on acceptance, -1 on FIFO write, unchanged when both occur.
- FIFO: circular buffer with wrap-around pointers. The head is presented while out_valid=1. A pop (out_valid & out_ready) and a push may occur in the same cycle at any occupancy; overflow is impossible by credit.
- Order: output order equals acceptance order (FIFO semantics).
- out_data/out_id read 0 when out_valid=0.
- busy = (inflight != 0) | (fifo_count != 0).
- blocks_done increments on each pop and wraps at 2^32.
- Reset mid-operation: all tags, counts and FIFO contents are discarded. The core has no reset, so stale core_dout values are ignored because their tags are cleared.

Test Plan:
- Single block: req0 with key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0, exactly LATENCY+2 cycles after acceptance; busy low afterwards; blocks_done=1.
- Contention: both requesters valid continuously for 8 blocks -> grants alternate 0,1,0,1… starting with req0; out_id sequence matches. req1 block with key 2b7e151628aed2a6abf7158809cf4f3c and plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready=0, req0 streams continuously -> exactly 16 acceptances, then req0_ready=0. Raise out_ready -> 16 in-order results; issue resumes one cycle after the first pop; no loss or duplication.
- Throughput: 100 back-to-back blocks with out_ready=1 -> one acceptance per cycle and one result per cycle once the pipeline is filled.
- Reset mid-flight: pulse reset_n low with 5 blocks in the pipeline and 3 in the FIFO -> out_valid=0, busy=0, blocks_done=0 immediately. No stale outputs appear; a new block afterwards completes correctly.
- Counter wrap: preset or force blocks_done to FFFFFFFF, pop one block -> 00000000.
